// File: rtl/wr_full_sync.sv
// rtl/wr_full_sync.sv - write-domain full/almost_full/level/overflow status of the async FIFO
`timescale 1ns/1ps
module wr_full_sync #(
  parameter int PTR_WIDTH   = 8,
  parameter int SYNC_STAGES = 2,
  parameter int AF_THRESH   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PTR_WIDTH-1:0] wr_g_nxt,
  input  logic [PTR_WIDTH-1:0] rd_ptr_gray,
  output logic [PTR_WIDTH-1:0] rd_ptr_sync,
  output logic                 full,
  output logic                 almost_full,
  output logic [PTR_WIDTH-1:0] wr_level,
  output logic                 ovf_err
);

  localparam logic [PTR_WIDTH-1:0] DEPTH     = PTR_WIDTH'(1) << (PTR_WIDTH - 1);
  localparam logic [PTR_WIDTH-1:0] AF_LEVEL  = DEPTH - PTR_WIDTH'(AF_THRESH);
  // Inverting the top two Gray bits of a pointer yields the pointer DEPTH entries ahead.
  localparam logic [PTR_WIDTH-1:0] FULL_MASK = PTR_WIDTH'(3) << (PTR_WIDTH - 2);

  logic [PTR_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [PTR_WIDTH-1:0] wbin_nxt;
  logic [PTR_WIDTH-1:0] rbin_s;
  logic [PTR_WIDTH-1:0] lvl_nxt;
  logic                 full_nxt;
  logic                 af_nxt;
  logic                 ovf_nxt;

  function automatic logic [PTR_WIDTH-1:0] gray2bin(input logic [PTR_WIDTH-1:0] g);
    logic [PTR_WIDTH-1:0] b;
    b = g;
    for (int i = PTR_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= rd_ptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign rd_ptr_sync = sync_q[SYNC_STAGES-1];

  assign wbin_nxt = gray2bin(wr_g_nxt);
  assign rbin_s   = gray2bin(rd_ptr_sync);
  assign lvl_nxt  = wbin_nxt - rbin_s;
  assign full_nxt = (wr_g_nxt == (rd_ptr_sync ^ FULL_MASK));
  assign af_nxt   = (lvl_nxt >= AF_LEVEL) && (lvl_nxt <= DEPTH);
  assign ovf_nxt  = (lvl_nxt > DEPTH);

  // No saturation once overflowed: flags keep tracking the raw level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_level    <= '0;
      ovf_err     <= 1'b0;
    end else begin
      full        <= full_nxt;
      almost_full <= af_nxt;
      wr_level    <= lvl_nxt;
      ovf_err     <= ovf_err | ovf_nxt;
    end
  end

endmodule

// File: tb/tb_wr_full_sync.sv
// tb/tb_wr_full_sync.sv - self-checking bench for wr_full_sync (PTR_WIDTH=4, DEPTH=8)
`timescale 1ns/1ps
module tb_wr_full_sync;
  localparam int PW    = 4;
  localparam int DEPTH = 8;
  localparam int AF    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [PW-1:0] wr_g_nxt = '0;
  logic [PW-1:0] rd_dir_g = '0;
  logic [PW-1:0] rd_rand_g;
  logic [PW-1:0] rd_ptr_gray;
  logic [PW-1:0] rd_ptr_sync;
  logic [PW-1:0] wr_level;
  logic          full;
  logic          almost_full;
  logic          ovf_err;
  logic          rd_run = 1'b0;
  int            rd_div = 1;
  int            rcnt;
  int            wcnt = 0;
  int            checks = 0;
  int            errors = 0;

  assign rd_ptr_gray = rd_run ? rd_rand_g : rd_dir_g;

  wr_full_sync #(.PTR_WIDTH(PW), .SYNC_STAGES(2), .AF_THRESH(AF)) dut (
    .clk(clk), .rst_n(rst_n), .wr_g_nxt(wr_g_nxt), .rd_ptr_gray(rd_ptr_gray),
    .rd_ptr_sync(rd_ptr_sync), .full(full), .almost_full(almost_full),
    .wr_level(wr_level), .ovf_err(ovf_err)
  );

  always #6 clk = ~clk;

  function automatic logic [PW-1:0] gray(input int n);
    logic [PW-1:0] b;
    b = PW'(n);
    return b ^ (b >> 1);
  endfunction

  // Read domain: updates land on times 1 mod 4, never on a clk edge or a sample point.
  initial begin
    int div_cnt;
    div_cnt = 0;
    rcnt = 0;
    rd_rand_g = '0;
    #1;
    forever begin
      if (!rd_run) begin
        rcnt = 0;
        rd_rand_g = '0;
        div_cnt = 0;
      end else begin
        div_cnt++;
        if (div_cnt >= rd_div) begin
          div_cnt = 0;
          if ($urandom_range(3) != 0 && wcnt > rcnt) begin
            rcnt++;
            rd_rand_g = gray(rcnt);
          end
        end
      end
      #4;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wr_g_nxt = '0;
    rd_dir_g = '0;
    wcnt = 0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({rd_ptr_sync, full, almost_full, wr_level, ovf_err} !== '0) begin
      errors++;
      $display("FAIL reset_state: got sync=%h full=%b af=%b lvl=%0d ovf=%b, expected all 0",
               rd_ptr_sync, full, almost_full, wr_level, ovf_err);
    end
    rst_n = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      wr_g_nxt = gray(n);
      tick();
    end
    checks++;
    if (wr_level !== 4'd5) begin
      errors++;
      $display("FAIL pre_reset_level: got %0d expected 5", wr_level);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rd_ptr_sync, full, almost_full, wr_level, ovf_err} !== '0) begin
      errors++;
      $display("FAIL async_reset: got lvl=%0d af=%b full=%b ovf=%b, expected all 0",
               wr_level, almost_full, full, ovf_err);
    end
  endtask

  task automatic test_fill();
    do_reset();
    tick();
    for (int n = 1; n <= DEPTH; n++) begin
      wr_g_nxt = gray(n);
      tick();
      checks++;
      if (wr_level !== PW'(n)) begin
        errors++;
        $display("FAIL fill_level: got %0d expected %0d", wr_level, n);
      end
      checks++;
      if (almost_full !== (n >= DEPTH - AF)) begin
        errors++;
        $display("FAIL fill_af: at level %0d got %b expected %b", n, almost_full, n >= DEPTH - AF);
      end
      checks++;
      if (full !== (n == DEPTH)) begin
        errors++;
        $display("FAIL fill_full: at level %0d got %b expected %b", n, full, n == DEPTH);
      end
    end
  endtask

  task automatic test_read_latency();
    rd_dir_g = gray(1);
    tick();
    checks++;
    if (rd_ptr_sync !== 4'd0 || full !== 1'b1) begin
      errors++;
      $display("FAIL rd_lat_edge_k: got sync=%h full=%b expected sync=0 full=1", rd_ptr_sync, full);
    end
    tick();
    checks++;
    if (rd_ptr_sync !== gray(1) || full !== 1'b1 || wr_level !== 4'd8) begin
      errors++;
      $display("FAIL rd_lat_edge_k1: got sync=%h full=%b lvl=%0d expected sync=%h full=1 lvl=8",
               rd_ptr_sync, full, wr_level, gray(1));
    end
    tick();
    checks++;
    if (full !== 1'b0 || wr_level !== 4'd7 || almost_full !== 1'b1) begin
      errors++;
      $display("FAIL rd_lat_edge_k2: got full=%b lvl=%0d af=%b expected full=0 lvl=7 af=1",
               full, wr_level, almost_full);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    rd_dir_g = gray(13);
    tick();
    tick();
    tick();
    wr_g_nxt = gray(13);
    tick();
    checks++;
    if (wr_level !== 4'd0) begin
      errors++;
      $display("FAIL wrap_start: got %0d expected 0", wr_level);
    end
    for (int n = 14; n <= 21; n++) begin
      wr_g_nxt = gray(n);
      tick();
    end
    checks++;
    if (wr_level !== 4'd8 || full !== 1'b1) begin
      errors++;
      $display("FAIL wrap_full: got lvl=%0d full=%b expected lvl=8 full=1", wr_level, full);
    end
    for (int r = 14; r <= 17; r++) begin
      rd_dir_g = gray(r);
      tick();
    end
    tick();
    tick();
    tick();
    checks++;
    if (wr_level !== 4'd4 || almost_full !== 1'b0 || full !== 1'b0 || ovf_err !== 1'b0) begin
      errors++;
      $display("FAIL wrap_drain: got lvl=%0d af=%b full=%b ovf=%b expected lvl=4 af=0 full=0 ovf=0",
               wr_level, almost_full, full, ovf_err);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    tick();
    wr_g_nxt = gray(9);
    tick();
    checks++;
    if (ovf_err !== 1'b1 || wr_level !== 4'd9 || full !== 1'b0 || almost_full !== 1'b0) begin
      errors++;
      $display("FAIL ovf_set: got ovf=%b lvl=%0d full=%b af=%b expected ovf=1 lvl=9 full=0 af=0",
               ovf_err, wr_level, full, almost_full);
    end
    wr_g_nxt = gray(4);
    tick();
    tick();
    checks++;
    if (ovf_err !== 1'b1 || wr_level !== 4'd4) begin
      errors++;
      $display("FAIL ovf_sticky: got ovf=%b lvl=%0d expected ovf=1 lvl=4", ovf_err, wr_level);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (ovf_err !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got %b expected 0", ovf_err);
    end
  endtask

  task automatic test_random(input int div, input int cycles);
    int  occ;
    int  inc;
    do_reset();
    rd_div = div;
    rd_run = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      inc = ($urandom_range(3) != 0 && !full) ? 1 : 0;
      wr_g_nxt = gray(wcnt + inc);
      tick();
      wcnt += inc;
      occ = wcnt - rcnt;
      checks++;
      if (full !== (wr_level == 4'd8)) begin
        errors++;
        $display("FAIL rand_full_consistent: div=%0d full=%b lvl=%0d", div, full, wr_level);
      end
      checks++;
      if (int'(wr_level) < occ) begin
        errors++;
        $display("FAIL rand_level_bound: div=%0d got lvl=%0d below true occupancy %0d", div, wr_level, occ);
      end
      checks++;
      if (almost_full !== (wr_level >= 4'(DEPTH - AF))) begin
        errors++;
        $display("FAIL rand_af: div=%0d got af=%b at lvl=%0d", div, almost_full, wr_level);
      end
      checks++;
      if (ovf_err !== 1'b0) begin
        errors++;
        $display("FAIL rand_ovf: div=%0d got ovf=1 expected 0", div);
      end
    end
    for (int c = 0; c < 200; c++) begin
      tick();
    end
    occ = wcnt - rcnt;
    checks++;
    if (int'(wr_level) !== occ || full !== 1'b0) begin
      errors++;
      $display("FAIL rand_drain: div=%0d got lvl=%0d full=%b expected lvl=%0d full=0",
               div, wr_level, full, occ);
    end
    rd_run = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_read_latency();
    test_wrap();
    test_overflow();
    test_random(9, 600);
    test_random(1, 600);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
